// File: rtl/instr_sequencer.sv
// instr_sequencer
//   Instruction-side driver for simple_cpu. Holds a small loadable program
//   store and walks it with a fetch/issue FSM, presenting each non-zero word
//   on the CPU instruction input for a class-dependent number of cycles.
//   Execution stops at the all-zero HALT word or at the last store address.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous, active-low reset
//   prog_we      program store write enable (honoured only in IDLE/HALTED)
//   prog_addr    program store write address
//   prog_data    program store write data
//   start        single-cycle pulse, begins execution at address 0
//   instruction  word driven to simple_cpu (zero when nothing is issued)
//   instr_valid  high while instruction carries an issued word
//   pc           address of the current or next fetched word
//   busy         high in FETCH or ISSUE
//   done         high in HALTED

module instr_sequencer #(
  parameter int INSTR_WIDTH    = 20,
  parameter int PROG_ADDR_BITS = 4,
  parameter int ALU_CYCLES     = 3,
  parameter int LOAD_CYCLES    = 4,
  parameter int STORE_CYCLES   = 3,
  parameter int NOP_CYCLES     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      prog_we,
  input  logic [PROG_ADDR_BITS-1:0] prog_addr,
  input  logic [INSTR_WIDTH-1:0]    prog_data,
  input  logic                      start,
  output logic [INSTR_WIDTH-1:0]    instruction,
  output logic                      instr_valid,
  output logic [PROG_ADDR_BITS-1:0] pc,
  output logic                      busy,
  output logic                      done
);

  localparam int DEPTH = 1 << PROG_ADDR_BITS;
  localparam logic [PROG_ADDR_BITS-1:0] PC_LAST = '1;
  localparam logic [PROG_ADDR_BITS-1:0] PC_ONE  = 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    HALTED
  } state_t;

  state_t                    state, state_next;
  logic [PROG_ADDR_BITS-1:0] pc_next;
  logic [INSTR_WIDTH-1:0]    instr_next;
  logic                      valid_next;
  logic [7:0]                count, count_next;
  logic                      busy_next, done_next;
  logic [INSTR_WIDTH-1:0]    mem [DEPTH];
  logic [INSTR_WIDTH-1:0]    fetch_word;
  logic [1:0]                fetch_class;
  logic [7:0]                fetch_hold;

  // The store is read combinationally at pc so FETCH can decide in one cycle.
  assign fetch_word  = mem[pc];
  assign fetch_class = fetch_word[INSTR_WIDTH-1 -: 2];

  // Hold length chosen from the two class bits of the word being fetched.
  always_comb begin
    fetch_hold = 8'(NOP_CYCLES);
    case (fetch_class)
      2'b01:   fetch_hold = 8'(ALU_CYCLES);
      2'b10:   fetch_hold = 8'(LOAD_CYCLES);
      2'b11:   fetch_hold = 8'(STORE_CYCLES);
      default: fetch_hold = 8'(NOP_CYCLES);
    endcase
  end

  // Program store writes are only accepted while the sequencer is not
  // running, so a program can never be modified underneath itself. The store
  // is deliberately left out of reset so a program survives a reset.
  always_ff @(posedge clk) begin
    if (prog_we && (state == IDLE || state == HALTED)) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // State and output register. Everything the CPU sees is a flop, so the
  // asynchronous reset clears instruction/instr_valid without waiting for
  // an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= '0;
      instruction <= '0;
      instr_valid <= 1'b0;
      count       <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      instruction <= instr_next;
      instr_valid <= valid_next;
      count       <= count_next;
      busy        <= busy_next;
      done        <= done_next;
    end
  end

  // Next-state and next-output logic. FETCH always leaves instruction at
  // zero for its cycle, which gives the one-cycle bubble between issued
  // words. The last store address halts instead of wrapping pc to zero.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    instr_next = instruction;
    valid_next = instr_valid;
    count_next = count;

    case (state)
      IDLE: begin
        if (start) begin
          state_next = FETCH;
          pc_next    = '0;
        end
      end
      FETCH: begin
        if (fetch_word == '0) begin
          state_next = HALTED;
          instr_next = '0;
          valid_next = 1'b0;
        end else begin
          state_next = ISSUE;
          instr_next = fetch_word;
          valid_next = 1'b1;
          count_next = fetch_hold;
        end
      end
      ISSUE: begin
        if (count > 8'd1) begin
          count_next = count - 8'd1;
        end else begin
          count_next = 8'd0;
          instr_next = '0;
          valid_next = 1'b0;
          if (pc == PC_LAST) begin
            state_next = HALTED;
          end else begin
            pc_next    = pc + PC_ONE;
            state_next = FETCH;
          end
        end
      end
      HALTED: begin
        if (start) begin
          state_next = FETCH;
          pc_next    = '0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next == FETCH) || (state_next == ISSUE);
    done_next = (state_next == HALTED);
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer
//   Directed bench for instr_sequencer: a cycle-by-cycle vector table for a
//   three-word program, plus hand-written sequences for class timing, the end
//   of the store, ignored start/write while busy, simultaneous start+write and
//   an asynchronous reset in the middle of an issue.

module tb_instr_sequencer;

  logic        clk;
  logic        rst;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [19:0] prog_data;
  logic        start;
  logic [19:0] instruction;
  logic        instr_valid;
  logic [3:0]  pc;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  localparam logic [19:0] W_ADD   = 20'b01000111000000000000;
  localparam logic [19:0] W_SUB   = 20'b01010011000000000000;
  localparam logic [19:0] W_STORE = 20'b11011000000011110000;
  localparam logic [19:0] W_LOAD  = 20'b10111000000011110000;
  localparam logic [19:0] W_FILL  = 20'h40000;

  typedef struct {
    logic        start;
    logic [19:0] expInstr;
    logic        expValid;
    logic [3:0]  expPc;
    logic        expBusy;
    logic        expDone;
  } vec_t;

  vec_t vecs [11];

  instr_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .start       (start),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .done        (done)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so a stuck design still ends the run with a report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare every output against the expected values in one comparison.
  task automatic checkOutput(input string name, input logic [19:0] eInstr,
                             input logic eValid, input logic [3:0] ePc,
                             input logic eBusy, input logic eDone);
    checks++;
    if (instruction !== eInstr || instr_valid !== eValid || pc !== ePc ||
        busy !== eBusy || done !== eDone) begin
      failures++;
      $display("[TB] FAIL %s: got instr=%h valid=%b pc=%0d busy=%b done=%b, want instr=%h valid=%b pc=%0d busy=%b done=%b",
               name, instruction, instr_valid, pc, busy, done,
               eInstr, eValid, ePc, eBusy, eDone);
    end
  endtask

  // Single scalar comparison helper.
  task automatic checkValue(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Drive one table row, clock it, and compare.
  task automatic applyStimulus(input vec_t v, input int idx);
    start = v.start;
    tick();
    start = 1'b0;
    checkOutput($sformatf("prog3_row%0d", idx), v.expInstr, v.expValid,
                v.expPc, v.expBusy, v.expDone);
  endtask

  task automatic loadWord(input logic [3:0] addr, input logic [19:0] data);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_data = data;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait (bounded) for the next issued word, then measure how long it stays
  // valid and confirm it never changes while valid.
  task automatic measureIssue(input string name, input logic [19:0] expWord,
                              input int expLen);
    int guard = 0;
    int len   = 0;
    bit bad   = 0;
    while (!instr_valid && guard < 20) begin
      tick();
      guard++;
    end
    if (!instr_valid) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_wait: got no instr_valid within 20 cycles, want an issue", name);
      return;
    end
    while (instr_valid && len < 300) begin
      if (instruction !== expWord) bad = 1;
      len++;
      tick();
    end
    checkValue({name, "_len"}, len, expLen);
    checkValue({name, "_word"}, int'(bad), 0);
  endtask

  task automatic waitDone(input string name);
    int guard = 0;
    while (!done && guard < 40) begin
      tick();
      guard++;
    end
    checkValue({name, "_done"}, int'(done), 1);
  endtask

  initial begin
    rst       = 1'b0;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    start     = 1'b0;

    vecs[0]  = '{1'b1, 20'h0,  1'b0, 4'd0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, W_ADD,  1'b1, 4'd0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, W_ADD,  1'b1, 4'd0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, W_ADD,  1'b1, 4'd0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 20'h0,  1'b0, 4'd1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, W_SUB,  1'b1, 4'd1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, W_SUB,  1'b1, 4'd1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, W_SUB,  1'b1, 4'd1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 20'h0,  1'b0, 4'd2, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 20'h0,  1'b0, 4'd2, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 20'h0,  1'b0, 4'd2, 1'b0, 1'b1};

    // Reset and idle behaviour.
    repeat (3) tick();
    checkOutput("in_reset", 20'h0, 1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) tick();
    checkOutput("idle_no_start", 20'h0, 1'b0, 4'd0, 1'b0, 1'b0);

    // Three-word program, checked cycle by cycle from the table.
    loadWord(4'd0, W_ADD);
    loadWord(4'd1, W_SUB);
    loadWord(4'd2, 20'h0);
    for (int i = 0; i < 11; i++) applyStimulus(vecs[i], i);

    // Class-dependent hold lengths with pass-through of all fields.
    loadWord(4'd0, W_STORE);
    loadWord(4'd1, W_LOAD);
    loadWord(4'd2, 20'h0);
    pulseStart();
    measureIssue("store", W_STORE, 3);
    measureIssue("load", W_LOAD, 4);
    waitDone("class");
    checkValue("class_pc", int'(pc), 2);

    // Store full of ALU words: sixteen issues, then halt at the last address.
    for (int a = 0; a < 16; a++) loadWord(4'(a), W_FILL);
    pulseStart();
    for (int a = 0; a < 16; a++) measureIssue($sformatf("fill%0d", a), W_FILL, 3);
    waitDone("fill");
    repeat (3) tick();
    checkOutput("fill_halted_nowrap", 20'h0, 1'b0, 4'd15, 1'b0, 1'b1);

    // start and a store write during ISSUE are both ignored.
    loadWord(4'd0, W_ADD);
    loadWord(4'd1, 20'h0);
    pulseStart();
    begin
      int guard = 0;
      int len   = 0;
      while (!instr_valid && guard < 20) begin
        tick();
        guard++;
      end
      checkValue("busy_evt_valid", int'(instr_valid), 1);
      len = 1;
      start     = 1'b1;
      prog_we   = 1'b1;
      prog_addr = 4'd0;
      prog_data = 20'hFFFFF;
      tick();
      start   = 1'b0;
      prog_we = 1'b0;
      while (instr_valid && len < 20) begin
        len++;
        tick();
      end
      checkValue("busy_evt_len", len, 3);
    end
    waitDone("busy_evt");
    checkValue("busy_evt_pc", int'(pc), 1);
    pulseStart();
    measureIssue("rerun_mem0", W_ADD, 3);
    waitDone("rerun");

    // Asynchronous reset during the second hold cycle of a LOAD.
    loadWord(4'd0, W_LOAD);
    loadWord(4'd1, 20'h0);
    pulseStart();
    begin
      int guard = 0;
      while (!instr_valid && guard < 20) begin
        tick();
        guard++;
      end
      tick();
      checkOutput("load_2nd_cycle", W_LOAD, 1'b1, 4'd0, 1'b1, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("async_reset", 20'h0, 1'b0, 4'd0, 1'b0, 1'b0);
    end
    repeat (2) tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    pulseStart();
    measureIssue("after_reset_load", W_LOAD, 4);
    waitDone("after_reset");
    checkValue("after_reset_pc", int'(pc), 1);

    // start together with a write while HALTED: the write is fetched.
    prog_we   = 1'b1;
    prog_addr = 4'd0;
    prog_data = W_FILL;
    start     = 1'b1;
    tick();
    prog_we = 1'b0;
    start   = 1'b0;
    measureIssue("start_with_write", W_FILL, 3);
    waitDone("start_with_write");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Instruction-side driver for simple_cpu: a loadable program store plus a fetch/issue FSM.
- Replaces hand-timed instruction stimulus. Each 20-bit instruction is presented to the CPU's instruction input for a class-dependent number of cycles.
- Stops at a HALT word or at the end of the program store.
- Sits between the program loader and the simple_cpu instruction port, in the same clock domain.

Parameters:
- INSTR_WIDTH, 20, instruction word width (must be 20 for the field map below).
- PROG_ADDR_BITS, 4, program store depth = 2^PROG_ADDR_BITS words.
- ALU_CYCLES, 3, hold cycles for class 01 (ADD/SUB).
- LOAD_CYCLES, 4, hold cycles for class 10 (LOAD_R).
- STORE_CYCLES, 3, hold cycles for class 11 (STORE_R).
- NOP_CYCLES, 1, hold cycles for class 00 non-zero words. All *_CYCLES must be >= 1 and < 256.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- prog_we  input  1  program store write enable.
- prog_addr  input  PROG_ADDR_BITS  program store write address.
- prog_data  input  INSTR_WIDTH  program store write data.
- start  input  1  single-cycle pulse that begins execution at address 0.
- instruction  output  INSTR_WIDTH  word driven to simple_cpu.
- instr_valid  output  1  high while instruction carries an issued word.
- pc  output  PROG_ADDR_BITS  address of the current or next fetched word.
- busy  output  1  high in FETCH or ISSUE.
- done  output  1  high in HALTED.

Behaviour:
- Field map: [19:18] class (00 NOP, 01 ALU, 10 LOAD, 11 STORE); [17:16] X1; [15:14] X2; [13:12] X3; [11:4] 8-bit offset; [3:0] ALU func. The sequencer only decodes the class and HALT; all other fields pass through unmodified.
- HALT is the all-zero word 20'h00000. Other class-00 words are NOPs.
- Reset (rst=0, asynchronous): state=IDLE, pc=0, instruction=0, instr_valid=0, busy=0, done=0, hold counter=0. The program store is NOT cleared.
- Program store:
  - Write is synchronous: when prog_we=1 and state is IDLE or HALTED, mem[prog_addr] <= prog_data.
  - Writes in FETCH or ISSUE are ignored.
  - Read is combinational at address pc.
- FSM:
  - IDLE: start=1 -> FETCH with pc=0. Otherwise stay.
  - FETCH (1 cycle):
    - mem[pc]==0 -> HALTED, instruction=0.
    - Otherwise latch instruction<=mem[pc], counter<=hold(class), instr_valid<=1, -> ISSUE.
  - ISSUE: instruction is held stable.
    - counter>1: counter decrements.
    - counter==1: instr_valid<=0, instruction<=0, then:
      - pc==2^PROG_ADDR_BITS-1: -> HALTED, pc unchanged. pc does not wrap.
      - Otherwise pc<=pc+1, -> FETCH.
  - HALTED: done=1. start=1 -> FETCH with pc=0, done<=0.
- Cycle timing:
  - Every issued word is visible for exactly hold(class) cycles.
  - A one-cycle bubble follows each issued word: instruction=0, instr_valid=0 during FETCH.
  - Latency from the start pulse to the first instr_valid=1 is 2 cycles (start sampled, then FETCH).
- start while busy=1 is ignored, with no restart.
- start and prog_we asserted together in IDLE/HALTED: the write completes and execution starts. The first fetch occurs the cycle after the write, so the write is visible.
- Reset mid-ISSUE: outputs drop to reset values immediately (asynchronous). instr_valid and instruction go to 0 before the next edge.
- busy = state in {FETCH, ISSUE}. done = state==HALTED. Both are registered state decodes with no glitches.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles, release, run 5 cycles without start -> instruction=0, instr_valid=0, busy=0, done=0, pc=0.
- Load and run a 3-word program:
  - Program: mem0=20'b01000111000000000000, mem1=20'b01010011000000000000, mem2=0; pulse start.
  - Required: mem0 valid for 3 cycles, 1 bubble, mem1 valid for 3 cycles, 1 bubble, then done=1 with pc=2.
- Class timing:
  - Program: mem0=20'b11011000000011110000 (STORE), mem1=20'b10111000000011110000 (LOAD), mem2=0.
  - Required: STORE held 3 cycles, LOAD held 4 cycles, instruction bits pass through unchanged.
- End of store: fill all 16 words with 20'h40000 (ALU, no HALT) -> 16 issues of 3 cycles each, then HALTED with pc=15 and no wrap to 0.
- Ignored events:
  - During ISSUE of mem0, pulse start and write prog_addr=0 with 20'hFFFFF.
  - Required: no restart, and mem0 still reads its original value after HALT (verified by a rerun).
- Asynchronous reset mid-issue: drop rst during the 2nd hold cycle of a LOAD -> instruction=0 and instr_valid=0 within the same cycle. After release and start, the program reruns from pc=0 with the store intact.
